// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, addresses a combinational ROM and
// queues {pc, instr} pairs in a two-entry buffer for decode.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic [31:0] pc_reg, pc_next;
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic        wr_ptr_reg, wr_ptr_next;

    logic [31:0] entry_pc_reg    [BUF_DEPTH];
    logic [31:0] entry_instr_reg [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] wr_en;

    logic pop;
    logic push;

    assign out_valid = (count_reg != 2'd0);
    assign pop       = out_valid & out_ready;
    // A redirect suppresses the fetch; the pipeline refills from the target next cycle.
    assign push      = ~redirect_valid & ((count_reg < 2'd2) | pop);

    assign imem_addr = pc_reg;
    assign out_pc    = entry_pc_reg[rd_ptr_reg];
    assign out_instr = entry_instr_reg[rd_ptr_reg];

    always_comb begin
        pc_next     = pc_reg;
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (redirect_valid) begin
            pc_next     = {redirect_pc[31:2], 2'b00};
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else begin
            if (push) begin
                pc_next     = pc_reg + 32'd4;
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg     <= RESET_PC;
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            pc_reg     <= pc_next;
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            assign wr_en[gi] = push & (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_pc_reg[i]    <= 32'd0;
                entry_instr_reg[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (wr_en[i]) begin
                    entry_pc_reg[i]    <= pc_reg;
                    entry_instr_reg[i] <= imem_instr;
                end
            end
        end
    end

endmodule
